// File: rtl/eth_rx_frame_buffer_pkg.sv
// Shared types and constants for the Ethernet receive frame buffer.
// The FSM encoding and the drop counter ceiling live here so every block agrees on them.
package eth_rx_frame_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } rx_state_t;

    localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

    // Frame byte counter width: holds MAX_LEN + 1 for MAX_LEN up to 8191.
    localparam int CNT_W = 14;

endpackage

// File: rtl/eth_rx_frame_buffer_sync_fifo.sv
// Plain synchronous FWFT FIFO used as the frame length queue.
// The head is presented combinationally and reads as zero while the queue is empty.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB tells a full queue apart from an empty one.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clk_en) begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en && do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/eth_rx_frame_buffer.sv
// Receive frame buffer: packs MAC bytes into words, commits good frames atomically and
// rolls back bad ones, exposing data words and frame lengths as two FWFT queues.
module eth_rx_frame_buffer
    import eth_rx_frame_buffer_pkg::*;
#(
    parameter int OUT_W   = 32,
    parameter int DATA_AW = 10,
    parameter int LEN_AW  = 4,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             rx_write,
    input  logic             rx_eof,
    input  logic             rx_err,
    input  logic [7:0]       rx_dbout,
    input  logic             rx_data_fifo_read,
    input  logic             rx_len_fifo_read,
    output logic [OUT_W-1:0] rx_data_fifo_data,
    output logic [15:0]      rx_len_fifo_data,
    output logic             rx_data_fifo_empty,
    output logic             rx_data_fifo_full,
    output logic             rx_len_fifo_empty,
    output logic             rx_len_fifo_full,
    output logic [15:0]      drop_cnt
);

    localparam int                NB        = OUT_W / 8;
    localparam int                LANE_W    = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NB - 1);
    localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);
    localparam logic [DATA_AW:0]  PTR_ONE   = {{DATA_AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_LEN);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == DROP_CNT_MAX) ? v : v + 16'd1;
    endfunction

    logic              wr_p0;
    logic              eof_p0;
    logic              err_p0;
    logic [7:0]        byte_p0;

    rx_state_t         state;
    rx_state_t         state_n;
    logic [DATA_AW:0]  wr_spec;
    logic [DATA_AW:0]  wr_spec_n;
    logic [DATA_AW:0]  commit_ptr;
    logic [DATA_AW:0]  commit_n;
    logic [DATA_AW:0]  rd_ptr;
    logic [LANE_W-1:0] lane;
    logic [LANE_W-1:0] lane_n;
    logic [OUT_W-1:0]  acc;
    logic [OUT_W-1:0]  acc_n;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_n;
    logic [15:0]       drop_n;

    logic [OUT_W-1:0]  mem [2**DATA_AW];
    logic              mem_we;
    logic [OUT_W-1:0]  mem_wdata;
    logic [OUT_W-1:0]  lane_mask;
    logic [LANE_W+2:0] shamt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              word_done;
    logic              spec_full;
    logic              frame_ok;
    logic              len_push;
    logic [15:0]       len_in;
    logic              len_full;
    logic              data_empty;

    // Input stage: MAC strobes and byte registered once before any processing.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            wr_p0  <= 1'b0;
            eof_p0 <= 1'b0;
            err_p0 <= 1'b0;
        end else if (clk_en) begin
            wr_p0  <= rx_write;
            eof_p0 <= rx_eof;
            err_p0 <= rx_err;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clk_en) begin
            byte_p0 <= rx_dbout;
        end
    end

    // Space is judged against the speculative pointer so a frame can never overrun unread data.
    assign spec_full  = (wr_spec[DATA_AW] != rd_ptr[DATA_AW]) &&
                        (wr_spec[DATA_AW-1:0] == rd_ptr[DATA_AW-1:0]);
    assign data_empty = (commit_ptr == rd_ptr);

    always_comb begin
        state_n   = state;
        wr_spec_n = wr_spec;
        commit_n  = commit_ptr;
        lane_n    = lane;
        acc_n     = acc;
        count_n   = count;
        drop_n    = drop_cnt;
        mem_we    = 1'b0;
        len_push  = 1'b0;
        cnt_inc   = count + CNT_ONE;
        word_done = eof_p0 || (lane == LANE_LAST);
        shamt     = {lane, 3'b000};
        // Lanes at and above the current one are masked off, so stale accumulator bytes never leak.
        lane_mask = (OUT_W'(1) << shamt) - OUT_W'(1);
        mem_wdata = (acc & lane_mask) | (OUT_W'(byte_p0) << shamt);
        frame_ok  = !err_p0 && (cnt_inc >= MIN_C) && (cnt_inc <= MAX_C) && !spec_full;

        if (wr_p0) begin
            if (state == ST_DROP) begin
                if (eof_p0) begin
                    state_n = ST_IDLE;
                end
            end else if ((state == ST_IDLE) && len_full) begin
                drop_n  = sat_inc(drop_cnt);
                state_n = eof_p0 ? ST_IDLE : ST_DROP;
            end else if (eof_p0) begin
                state_n = ST_IDLE;
                lane_n  = '0;
                acc_n   = '0;
                count_n = '0;
                if (frame_ok) begin
                    mem_we    = 1'b1;
                    wr_spec_n = wr_spec + PTR_ONE;
                    commit_n  = wr_spec + PTR_ONE;
                    len_push  = 1'b1;
                end else begin
                    wr_spec_n = commit_ptr;
                    drop_n    = sat_inc(drop_cnt);
                end
            end else if ((cnt_inc > MAX_C) || (word_done && spec_full)) begin
                state_n   = ST_DROP;
                wr_spec_n = commit_ptr;
                drop_n    = sat_inc(drop_cnt);
                lane_n    = '0;
                acc_n     = '0;
                count_n   = '0;
            end else begin
                state_n = ST_RECV;
                count_n = cnt_inc;
                if (word_done) begin
                    mem_we    = 1'b1;
                    wr_spec_n = wr_spec + PTR_ONE;
                    lane_n    = '0;
                    acc_n     = '0;
                end else begin
                    lane_n = lane + LANE_ONE;
                    acc_n  = mem_wdata;
                end
            end
        end
    end

    // Processing stage: FSM, pointers, packing state and drop counter.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state      <= ST_IDLE;
            wr_spec    <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            lane       <= '0;
            count      <= '0;
            drop_cnt   <= '0;
        end else if (clk_en) begin
            state      <= state_n;
            wr_spec    <= wr_spec_n;
            commit_ptr <= commit_n;
            lane       <= lane_n;
            count      <= count_n;
            drop_cnt   <= drop_n;
            if (rx_data_fifo_read && !data_empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clk_en) begin
            acc <= acc_n;
            if (mem_we) begin
                mem[wr_spec[DATA_AW-1:0]] <= mem_wdata;
            end
        end
    end

    assign rx_data_fifo_empty = data_empty;
    assign rx_data_fifo_full  = (commit_ptr[DATA_AW] != rd_ptr[DATA_AW]) &&
                                (commit_ptr[DATA_AW-1:0] == rd_ptr[DATA_AW-1:0]);
    assign rx_data_fifo_data  = data_empty ? '0 : mem[rd_ptr[DATA_AW-1:0]];

    assign len_in           = 16'(cnt_inc);
    assign rx_len_fifo_full = len_full;

    sync_fifo #(
        .WIDTH (16),
        .AW    (LEN_AW)
    ) u_len_fifo (
        .clk       (clk_i),
        .reset     (reset),
        .clk_en    (clk_en),
        .push      (len_push),
        .push_data (len_in),
        .pop       (rx_len_fifo_read),
        .pop_data  (rx_len_fifo_data),
        .empty     (rx_len_fifo_empty),
        .full      (len_full)
    );

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Bench for eth_rx_frame_buffer: a default 32-bit instance and a small 8-bit instance,
// driven with random frames and compared against a frame-level queue model.
module tb_eth_rx_frame_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        clk_en;

    logic        a_wr, a_eof, a_err, a_drd, a_lrd;
    logic [7:0]  a_byte;
    logic [31:0] a_data;
    logic [15:0] a_len, a_drop;
    logic        a_de, a_df, a_le, a_lf;

    logic        b_wr, b_eof, b_err, b_drd, b_lrd;
    logic [7:0]  b_byte;
    logic [7:0]  b_data;
    logic [15:0] b_len, b_drop;
    logic        b_de, b_df, b_le, b_lf;

    eth_rx_frame_buffer dut_a (
        .clk_i (clk), .reset (reset), .clk_en (clk_en),
        .rx_write (a_wr), .rx_eof (a_eof), .rx_err (a_err), .rx_dbout (a_byte),
        .rx_data_fifo_read (a_drd), .rx_len_fifo_read (a_lrd),
        .rx_data_fifo_data (a_data), .rx_len_fifo_data (a_len),
        .rx_data_fifo_empty (a_de), .rx_data_fifo_full (a_df),
        .rx_len_fifo_empty (a_le), .rx_len_fifo_full (a_lf),
        .drop_cnt (a_drop)
    );

    eth_rx_frame_buffer #(
        .OUT_W (8), .DATA_AW (4), .LEN_AW (4), .MIN_LEN (16), .MAX_LEN (1518)
    ) dut_b (
        .clk_i (clk), .reset (reset), .clk_en (clk_en),
        .rx_write (b_wr), .rx_eof (b_eof), .rx_err (b_err), .rx_dbout (b_byte),
        .rx_data_fifo_read (b_drd), .rx_len_fifo_read (b_lrd),
        .rx_data_fifo_data (b_data), .rx_len_fifo_data (b_len),
        .rx_data_fifo_empty (b_de), .rx_data_fifo_full (b_df),
        .rx_len_fifo_empty (b_le), .rx_len_fifo_full (b_lf),
        .drop_cnt (b_drop)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  frm[$];
    logic [31:0] qd_a[$];
    logic [31:0] qd_b[$];
    logic [15:0] ql_a[$];
    logic [15:0] ql_b[$];
    int          drop_exp[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic w, input logic e, input logic r,
                          input logic [7:0] d);
        if (sel == 0) begin
            a_wr = w; a_eof = e; a_err = r; a_byte = d;
        end else begin
            b_wr = w; b_eof = e; b_err = r; b_byte = d;
        end
    endtask

    task automatic make_frame(input int len, input bit rnd);
        frm.delete();
        for (int i = 0; i < len; i++) begin
            frm.push_back(rnd ? 8'($urandom) : 8'(i));
        end
    endtask

    // Frame-level reference: accepted iff error-free, within length limits, a length slot
    // is free at frame start and the whole frame fits beside what is already stored.
    task automatic model(input int sel, input bit err);
        int nb, depth, mn, nw, len, used, lused;
        bit ok;
        logic [31:0] w;
        len   = frm.size();
        nb    = (sel == 0) ? 4 : 1;
        depth = (sel == 0) ? 1024 : 16;
        mn    = (sel == 0) ? 64 : 16;
        used  = (sel == 0) ? qd_a.size() : qd_b.size();
        lused = (sel == 0) ? ql_a.size() : ql_b.size();
        nw    = (len + nb - 1) / nb;
        ok    = !err && (len >= mn) && (len <= 1518) && (lused < 16) && (used + nw <= depth);
        if (ok) begin
            for (int k = 0; k < nw; k++) begin
                w = 32'h0;
                for (int j = 0; j < nb; j++) begin
                    if (k * nb + j < len) w[8*j +: 8] = frm[k * nb + j];
                end
                if (sel == 0) qd_a.push_back(w);
                else          qd_b.push_back(w);
            end
            if (sel == 0) ql_a.push_back(16'(len));
            else          ql_b.push_back(16'(len));
        end else if (drop_exp[sel] < 65535) begin
            drop_exp[sel]++;
        end
    endtask

    // Sends frm; with ovl set, both queues are read on the eof edge and the commit edge.
    task automatic send(input int sel, input bit err, input bit stall, input bit ovl);
        bit last;
        for (int i = 0; i < frm.size(); i++) begin
            last = (i == frm.size() - 1);
            if (stall && $urandom_range(0, 7) == 0) begin
                set_in(sel, 1'b0, 1'b0, 1'b0, 8'h00);
                @(posedge clk); #1;
            end
            set_in(sel, 1'b1, last, err && last, frm[i]);
            if (stall && $urandom_range(0, 7) == 0) begin
                clk_en = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                clk_en = 1'b1;
            end
            if (ovl && last) begin
                chk("ovl_data0", a_data, qd_a.pop_front());
                chk("ovl_len0", 32'(a_len), 32'(ql_a.pop_front()));
                a_drd = 1'b1;
                a_lrd = 1'b1;
            end
            @(posedge clk); #1;
        end
        set_in(sel, 1'b0, 1'b0, 1'b0, 8'h00);
        if (ovl) begin
            chk("ovl_data1", a_data, qd_a.pop_front());
            chk("ovl_len1", 32'(a_len), 32'(ql_a.pop_front()));
            @(posedge clk); #1;
            a_drd = 1'b0;
            a_lrd = 1'b0;
        end
    endtask

    task automatic drain(input int sel);
        int n, nexp, budget;
        logic [31:0] e, got;
        repeat (2) @(posedge clk);
        #1;
        n = 0; budget = 4000;
        nexp = (sel == 0) ? qd_a.size() : qd_b.size();
        while (budget > 0 && ((sel == 0) ? !a_de : !b_de)) begin
            e = 32'h0;
            if (sel == 0) begin
                if (qd_a.size() > 0) e = qd_a.pop_front();
                got = a_data; a_drd = 1'b1;
            end else begin
                if (qd_b.size() > 0) e = qd_b.pop_front();
                got = 32'(b_data); b_drd = 1'b1;
            end
            chk("data_word", got, e);
            n++; budget--;
            @(posedge clk); #1;
        end
        a_drd = 1'b0; b_drd = 1'b0;
        chk("data_words", 32'(n), 32'(nexp));
        if (sel == 0) qd_a.delete(); else qd_b.delete();

        n = 0; budget = 100;
        nexp = (sel == 0) ? ql_a.size() : ql_b.size();
        while (budget > 0 && ((sel == 0) ? !a_le : !b_le)) begin
            e = 32'h0;
            if (sel == 0) begin
                if (ql_a.size() > 0) e = 32'(ql_a.pop_front());
                got = 32'(a_len); a_lrd = 1'b1;
            end else begin
                if (ql_b.size() > 0) e = 32'(ql_b.pop_front());
                got = 32'(b_len); b_lrd = 1'b1;
            end
            chk("len_entry", got, e);
            n++; budget--;
            @(posedge clk); #1;
        end
        a_lrd = 1'b0; b_lrd = 1'b0;
        chk("len_entries", 32'(n), 32'(nexp));
        if (sel == 0) ql_a.delete(); else ql_b.delete();
        chk("drop_cnt", (sel == 0) ? 32'(a_drop) : 32'(b_drop), 32'(drop_exp[sel]));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int nf, len;
        bit err;
        reset = 1'b1; clk_en = 1'b1;
        set_in(0, 1'b0, 1'b0, 1'b0, 8'h00);
        set_in(1, 1'b0, 1'b0, 1'b0, 8'h00);
        a_drd = 1'b0; a_lrd = 1'b0; b_drd = 1'b0; b_lrd = 1'b0;
        drop_exp[0] = 0; drop_exp[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_a_de", 32'(a_de), 32'd1);
        chk("rst_a_le", 32'(a_le), 32'd1);
        chk("rst_a_df", 32'(a_df), 32'd0);
        chk("rst_a_lf", 32'(a_lf), 32'd0);
        chk("rst_a_data", a_data, 32'd0);
        chk("rst_a_len", 32'(a_len), 32'd0);
        chk("rst_a_drop", 32'(a_drop), 32'd0);
        chk("rst_b_de", 32'(b_de), 32'd1);
        chk("rst_b_le", 32'(b_le), 32'd1);
        chk("rst_b_full", 32'({b_df, b_lf}), 32'd0);

        // 64-byte counting frame: eof latency and little-endian packing.
        make_frame(64, 1'b0);
        send(0, 1'b0, 1'b0, 1'b0);
        chk("eof1_de", 32'(a_de), 32'd1);
        chk("eof1_le", 32'(a_le), 32'd1);
        @(posedge clk); #1;
        chk("eof2_de", 32'(a_de), 32'd0);
        chk("eof2_le", 32'(a_le), 32'd0);
        chk("word0", a_data, 32'h03020100);
        chk("len64", 32'(a_len), 32'd64);
        model(0, 1'b0);
        drain(0);

        // 65-byte frame: last word holds one byte, upper lanes zero.
        make_frame(65, 1'b1);
        send(0, 1'b0, 1'b0, 1'b0);
        model(0, 1'b0);
        drain(0);

        // Errored 100-byte frame then a good 64-byte frame.
        make_frame(100, 1'b1);
        send(0, 1'b1, 1'b0, 1'b0);
        model(0, 1'b1);
        make_frame(64, 1'b1);
        send(0, 1'b0, 1'b0, 1'b0);
        model(0, 1'b0);
        drain(0);

        // Too long then too short: both dropped, nothing readable.
        make_frame(1519, 1'b1);
        send(0, 1'b0, 1'b0, 1'b0);
        model(0, 1'b0);
        make_frame(60, 1'b1);
        send(0, 1'b0, 1'b0, 1'b0);
        model(0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("long_short_de", 32'(a_de), 32'd1);
        chk("long_short_le", 32'(a_le), 32'd1);
        drain(0);

        // Reads coinciding with the commit and length push of a third frame.
        for (int f = 0; f < 2; f++) begin
            make_frame(64, 1'b1);
            send(0, 1'b0, 1'b0, 1'b0);
            model(0, 1'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        make_frame(70, 1'b1);
        send(0, 1'b0, 1'b0, 1'b1);
        model(0, 1'b0);
        drain(0);

        // Length queue full: the 17th frame is dropped.
        for (int f = 0; f < 17; f++) begin
            make_frame(64, 1'b1);
            send(0, 1'b0, 1'b0, 1'b0);
            model(0, 1'b0);
            if (f == 15) begin
                repeat (2) @(posedge clk);
                #1;
                chk("len_full", 32'(a_lf), 32'(ql_a.size() == 16));
            end
        end
        drain(0);

        // Random frames with gaps and clock-enable stalls.
        for (int r = 0; r < 20; r++) begin
            nf = $urandom_range(1, 3);
            for (int f = 0; f < nf; f++) begin
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(1500, 1530) : $urandom_range(1, 200);
                err = ($urandom_range(0, 7) == 0);
                make_frame(len, 1'b1);
                send(0, err, 1'b1, 1'b0);
                model(0, err);
            end
            drain(0);
        end

        // Reset in the middle of a frame, with a committed frame still stored.
        make_frame(64, 1'b1);
        send(0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            set_in(0, 1'b1, 1'b0, 1'b0, 8'($urandom));
            @(posedge clk); #1;
        end
        set_in(0, 1'b0, 1'b0, 1'b0, 8'h00);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        qd_a.delete(); ql_a.delete(); qd_b.delete(); ql_b.delete();
        drop_exp[0] = 0; drop_exp[1] = 0;
        chk("midrst_de", 32'(a_de), 32'd1);
        chk("midrst_le", 32'(a_le), 32'd1);
        chk("midrst_drop", 32'(a_drop), 32'd0);
        make_frame(64, 1'b1);
        send(0, 1'b0, 1'b0, 1'b0);
        model(0, 1'b0);
        drain(0);

        // Narrow instance: overflow drop, then a minimum-length frame that fits exactly.
        make_frame(20, 1'b1);
        send(1, 1'b0, 1'b0, 1'b0);
        model(1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("b_ovf_drop", 32'(b_drop), 32'(drop_exp[1]));
        chk("b_ovf_de", 32'(b_de), 32'd1);
        make_frame(16, 1'b1);
        send(1, 1'b0, 1'b0, 1'b0);
        model(1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("b_min_le", 32'(b_le), 32'd0);
        chk("b_full16", 32'(b_df), 32'd1);
        drain(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_rx_frame_buffer.md
ETH_RX_FRAME_BUFFER -- requirements
Module: eth_rx_frame_buffer

Interface
REQ-001 SHALL have parameter OUT_W, default 32, output word width in bits (8, 16 or 32); bytes per word NB = OUT_W/8.
REQ-002 SHALL have parameter DATA_AW, default 10, log2 data-buffer depth in words.
REQ-003 SHALL have parameter LEN_AW, default 4, log2 length-queue depth in entries.
REQ-004 SHALL have parameter MIN_LEN, default 64, minimum accepted frame length in bytes.
REQ-005 SHALL have parameter MAX_LEN, default 1518, maximum accepted frame length in bytes (at most 8191).
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk_i in 1 is the only clock; reset in 1 is the synchronous active-high reset.
REQ-007 SHALL have clk_en in 1: qualifies every state update; when low, all registers hold.
REQ-008 SHALL have rx_write in 1: a MAC byte is valid on rx_dbout.
REQ-009 SHALL have rx_eof in 1: asserted together with rx_write on the last byte of a frame.
REQ-010 SHALL have rx_err in 1: MAC frame error, sampled with the eof byte.
REQ-011 SHALL have rx_dbout in 8: MAC byte.
REQ-012 SHALL have rx_data_fifo_read in 1 and rx_len_fifo_read in 1: pop the head word and pop the head length.
REQ-013 SHALL have rx_data_fifo_data out OUT_W and rx_len_fifo_data out 16: head word and head frame length in bytes (true count, not minus one).
REQ-014 SHALL have rx_data_fifo_empty out 1, rx_data_fifo_full out 1, rx_len_fifo_empty out 1 and rx_len_fifo_full out 1.
REQ-015 SHALL have drop_cnt out 16: saturating count of dropped frames.

Function
REQ-016 SHALL register rx_write, rx_eof, rx_err and rx_dbout once before any processing; this is the input pipeline stage.
REQ-017 SHALL pack bytes little-endian: the first byte of a word goes to [7:0]; the word is written when NB bytes are collected or at eof; unused lanes of the last word are zero.
REQ-018 SHALL write words at a speculative write pointer; the read side sees only a committed pointer, and data-empty is derived from the committed pointer versus the read pointer.
REQ-019 SHALL implement FSM IDLE, RECV, DROP: IDLE->RECV on the first registered byte if the length queue is not full, else IDLE->DROP; on an eof byte, RECV->IDLE and DROP->IDLE.
REQ-020 SHALL, in RECV, move to DROP when the byte count would exceed MAX_LEN or a word write finds the data buffer full (speculative pointer versus read pointer).
REQ-021 SHALL, on a good eof (no rx_err, MIN_LEN <= count <= MAX_LEN), set the committed pointer to the speculative pointer and push the count onto the length queue.
REQ-022 SHALL, on a bad eof or on entry to DROP, restore the speculative pointer to the committed pointer and increment drop_cnt, saturating at 16'hFFFF; each frame increments drop_cnt exactly once.
REQ-023 SHALL, in DROP, discard all bytes until the eof byte.
REQ-024 SHALL, for an eof byte presented at cycle N, deassert both empties at cycle N+2.
REQ-025 SHALL present both outputs first-word-fall-through: the head is valid whenever the corresponding empty is low.
REQ-026 SHALL advance the read side one entry per read; a read while empty is ignored with no pointer change.
REQ-027 SHALL handle a simultaneous read and commit/push correctly in both queues.
REQ-028 SHALL wrap all pointers modulo depth, using one extra MSB for full/empty discrimination.
REQ-029 SHALL treat an eof without a preceding frame start (IDLE) as a 1-byte frame and drop it, since 1 < MIN_LEN.

Reset
REQ-030 SHALL, on reset, clear all pointers, drop_cnt and the packing lane counter and set FSM=IDLE, giving empties=1, fulls=0 and data outputs=0.
REQ-031 SHALL discard a frame in progress at reset; after release, reception resumes on the next rx_write, which opens a new frame.

Structure
REQ-032 SHALL keep the FSM state encoding and the drop_cnt saturation constant in the shared eth package.
REQ-033 SHALL instantiate one sub-module, sync_fifo (width and depth parametrised, FWFT), as the length queue; the data buffer SHALL be inline because it needs commit/rollback.

Verification
REQ-034 SHALL cover: 64-byte good frame, OUT_W=32 -> 16 words with bytes 0..3 in word 0 at [7:0]..[31:24]; length 64; empties low at eof+2.
REQ-035 SHALL cover: 65-byte frame -> 17 words, last word = {24'h0, byte64}; length 65.
REQ-036 SHALL cover: a 100-byte frame with rx_err at eof, followed by a good 64-byte frame -> drop_cnt=1; only the 64-byte frame is readable; length queue holds exactly one entry.
REQ-037 SHALL cover: a 1519-byte frame followed by a 60-byte frame -> drop_cnt=2; both queues stay empty.
REQ-038 SHALL cover: DATA_AW=4, OUT_W=8, a 20-byte frame with no reads -> overflow drop, drop_cnt=1, data-empty stays 1; after that, a 16-byte frame with MIN_LEN=16 is accepted.
REQ-039 SHALL cover: reset pulse mid-frame at byte 30 -> all empties 1; the next 64-byte frame is received intact.
